// File: rtl/de2_pio_ledr18_out_if.sv
// de2_pio_ledr18_out_if
//   Avalon-MM slave bus bundle for the LED output PIO.
//   master modport: drives address/chipselect/write_n/writedata, samples readdata.
//   slave modport : samples address/chipselect/write_n/writedata, drives readdata.
interface de2_pio_ledr18_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/de2_pio_ledr18_out.sv
// de2_pio_ledr18_out
//   Avalon-MM output PIO for an 18-bit LED bank with atomic set/clear and a
//   hardware blink engine (masked bits toggle every BLINK_HALF cycles).
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   bus      - Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port - registered LED outputs
// Register map (word address):
//   0 DATA (R/W), 1 OUTSET (W, reads DATA), 2 OUTCLEAR (W, reads DATA),
//   3 BLINK_MASK (R/W), 4 BLINK_HALF (R/W, write restarts blink),
//   5 STATUS (reads phase, write restarts blink), 6/7 read 0.
module de2_pio_ledr18_out #(
  parameter int unsigned            WIDTH       = 18,
  parameter int unsigned            CNT_WIDTH   = 24,
  parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                      clk,
  input  logic                      reset,
  de2_pio_ledr18_out_if.slave       bus,
  output logic [WIDTH-1:0]          out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_HALF   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic [WIDTH-1:0]     data_q,     data_d;
  logic [WIDTH-1:0]     mask_q,     mask_d;
  logic [CNT_WIDTH-1:0] half_q,     half_d;
  logic [CNT_WIDTH-1:0] counter_q,  counter_d;
  logic                 phase_q,    phase_d;
  logic [31:0]          readdata_q, readdata_d;
  logic [WIDTH-1:0]     out_port_q, out_port_d;

  logic                 wr_s;
  logic                 restart_s;
  logic                 unused_s;

  assign wr_s      = bus.chipselect & ~bus.write_n;
  // Writes to BLINK_HALF or STATUS restart the blink engine from phase 0.
  assign restart_s = wr_s & ((bus.address == ADDR_HALF) | (bus.address == ADDR_STATUS));
  // Upper writedata bits beyond the register widths are intentionally ignored.
  assign unused_s  = ^bus.writedata;

  // Register-map write decode.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    half_d = half_q;
    if (wr_s) begin
      case (bus.address)
        ADDR_DATA:  data_d = bus.writedata[WIDTH-1:0];
        ADDR_SET:   data_d = data_q | bus.writedata[WIDTH-1:0];
        ADDR_CLEAR: data_d = data_q & ~bus.writedata[WIDTH-1:0];
        ADDR_MASK:  mask_d = bus.writedata[WIDTH-1:0];
        ADDR_HALF:  half_d = bus.writedata[CNT_WIDTH-1:0];
        default:    data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

  // Blink counter and phase; a restart write wins over the count/wrap.
  always_comb begin
    counter_d = counter_q;
    phase_d   = phase_q;
    if (restart_s) begin
      counter_d = {CNT_WIDTH{1'b0}};
      phase_d   = 1'b0;
    end else if (half_q == {CNT_WIDTH{1'b0}}) begin
      counter_d = {CNT_WIDTH{1'b0}};
      phase_d   = 1'b0;
    end else if (counter_q == (half_q - CNT_WIDTH'(1))) begin
      counter_d = {CNT_WIDTH{1'b0}};
      phase_d   = ~phase_q;
    end else begin
      counter_d = counter_q + CNT_WIDTH'(1);
    end
  end

  // Read mux, sampled every cycle regardless of chipselect (1-cycle latency).
  always_comb begin
    readdata_d = 32'h0000_0000;
    case (bus.address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata_d = 32'(data_q);
      ADDR_MASK:                       readdata_d = 32'(mask_q);
      ADDR_HALF:                       readdata_d = 32'(half_q);
      ADDR_STATUS:                     readdata_d = {31'h0000_0000, phase_q};
      default:                         readdata_d = 32'h0000_0000;
    endcase
  end

  // Output: DATA with masked bits inverted during phase 1.
  always_comb begin
    out_port_d = data_q ^ (mask_q & {WIDTH{phase_q}});
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      mask_q     <= {WIDTH{1'b0}};
      half_q     <= {CNT_WIDTH{1'b0}};
      counter_q  <= {CNT_WIDTH{1'b0}};
      phase_q    <= 1'b0;
      readdata_q <= 32'h0000_0000;
      out_port_q <= RESET_VALUE;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      half_q     <= half_d;
      counter_q  <= counter_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
      out_port_q <= out_port_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign out_port     = out_port_q;

endmodule

// File: tb/tb_de2_pio_ledr18_out.sv
// tb_de2_pio_ledr18_out
//   Scoreboard bench: the driver computes the expected readdata/out_port for
//   each cycle from a cycle-count blink model and queues them; a monitor pops
//   and compares one cycle later.
module tb_de2_pio_ledr18_out;
  localparam int W  = 18;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  out_port;

  always #5 clk = ~clk;

  de2_pio_ledr18_out_if bus ();

  de2_pio_ledr18_out #(.WIDTH(W), .CNT_WIDTH(CW), .RESET_VALUE(18'h00000)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: registers plus cycles elapsed since last blink restart.
  logic [W-1:0]  m_data, m_mask;
  logic [CW-1:0] m_half;
  longint        m_k;

  logic [31:0]   q_rd[$];
  logic [W-1:0]  q_op[$];

  function automatic logic m_phase();
    if (m_half == 0) return 1'b0;
    return ((m_k / longint'(m_half)) % 2) == 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 18'h00000;
    m_mask = 18'h00000;
    m_half = 24'h000000;
    m_k    = 0;
  endtask

  // One bus cycle: drive at negedge, queue what the DUT must show after the edge.
  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    logic [31:0] rd;
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    case (a)
      3'd0, 3'd1, 3'd2: rd = 32'(m_data);
      3'd3:             rd = 32'(m_mask);
      3'd4:             rd = 32'(m_half);
      3'd5:             rd = {31'd0, m_phase()};
      default:          rd = 32'd0;
    endcase
    q_rd.push_back(rd);
    q_op.push_back(m_data ^ (m_mask & {W{m_phase()}}));
    if (cs && !wn && (a == 3'd4 || a == 3'd5)) m_k = 0;
    else m_k++;
    if (cs && !wn) begin
      case (a)
        3'd0:    m_data = wd[W-1:0];
        3'd1:    m_data = m_data | wd[W-1:0];
        3'd2:    m_data = m_data & ~wd[W-1:0];
        3'd3:    m_mask = wd[W-1:0];
        3'd4:    m_half = wd[CW-1:0];
        default: ;
      endcase
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cycle(a, 1'b1, 1'b0, wd);
  endtask

  task automatic rd_cycle(input logic [2:0] a);
    cycle(a, 1'b0, 1'b1, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd_cycle(3'd5);
  endtask

  // Direct check of the registered outputs right after the next edge.
  task automatic check_after_edge(input string name, input logic [31:0] exp_rd, input logic [W-1:0] exp_op);
    @(posedge clk);
    #2;
    check({name, "_rd"}, bus.readdata, exp_rd);
    check({name, "_op"}, 32'(out_port), 32'(exp_op));
  endtask

  // Assert reset mid-cycle, confirm outputs clear immediately, then release.
  task automatic do_reset();
    @(posedge clk);
    #2;
    if (q_rd.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries expected 0", q_rd.size());
      q_rd.delete();
      q_op.delete();
    end
    reset = 1'b1;
    #1;
    check("reset_rd", bus.readdata, 32'h0);
    check("reset_op", 32'(out_port), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare queued expectations one cycle after they were issued.
  always @(posedge clk) begin
    #1;
    if (!reset && q_rd.size() > 0) begin
      check("sb_readdata", bus.readdata, q_rd.pop_front());
      check("sb_out_port", 32'(out_port), 32'(q_op.pop_front()));
    end
  end

  initial begin
    int guard;
    reset          = 1'b1;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("por_rd", bus.readdata, 32'h0);
    check("por_op", 32'(out_port), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Read of DATA after reset.
    rd_cycle(3'd0);
    check_after_edge("rd0_after_reset", 32'h0, 18'h0);

    // Set/clear arithmetic.
    wr(3'd0, 32'h0003_FFFF);
    wr(3'd2, 32'h0000_0F0F);
    wr(3'd1, 32'h0000_0100);
    rd_cycle(3'd0);
    check_after_edge("setclr", 32'h0003_F1F0, 18'h3F1F0);

    // Blink: mask 3, half 4, data 0.
    wr(3'd3, 32'h0000_0003);
    wr(3'd0, 32'h0000_0000);
    wr(3'd4, 32'h0000_0004);
    idle(18);

    // Restart via STATUS while phase is 1.
    guard = 0;
    while (!m_phase() && guard < 16) begin
      idle(1);
      guard++;
    end
    check("phase1_reached", 32'(m_phase()), 32'h1);
    wr(3'd5, 32'hFFFF_FFFF);
    idle(12);

    // Half = 1 toggles every cycle, then half = 0 stops blinking.
    wr(3'd4, 32'h0000_0001);
    idle(6);
    wr(3'd4, 32'h0000_0000);
    idle(6);

    // Reset mid-blink.
    wr(3'd0, 32'h0001_5555);
    wr(3'd3, 32'h0003_FFFF);
    wr(3'd4, 32'h0000_0003);
    idle(5);
    do_reset();
    for (int a = 0; a < 8; a++) rd_cycle(3'(a));
    rd_cycle(3'd6);
    check_after_edge("addr6", 32'h0, 18'h0);
    rd_cycle(3'd7);
    check_after_edge("addr7", 32'h0, 18'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic        cs, wn;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 3) != 0);
      wn = $urandom_range(0, 1) == 1;
      wd = $urandom;
      if (a == 3'd4) wd = {$urandom_range(0, 255) < 8 ? 24'hFFFFFF : 24'h0, 8'($urandom_range(0, 5))} & 32'h00FF_FFFF;
      cycle(a, cs, wn, wd);
      if (i % 1000 == 999) do_reset();
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    check("queue_empty", 32'(q_rd.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
